// File: rtl/jtkcpu_pkg.sv
// rtl/jtkcpu_pkg.sv - shared jtkcpu constants and types
package jtkcpu_pkg;

  // Multiplier step counts, one multiplier bit per step
  localparam int MUL8_STEPS  = 8;
  localparam int MUL16_STEPS = 16;

  // The step counter is 4 bits wide, so it stops at steps-1
  localparam logic [3:0] MUL8_LAST  = 4'(MUL8_STEPS - 1);
  localparam logic [3:0] MUL16_LAST = 4'(MUL16_STEPS - 1);

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/jtkcpu_mul.sv
// rtl/jtkcpu_mul.sv - sequential 8x8 / 16x16 shift-and-add multiplier
module jtkcpu_mul
  import jtkcpu_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic        len,
  input  logic        start,
  input  logic        sign,
  output logic [31:0] prod,
  output logic        busy,
  output logic        z,
  output logic        n
);

  mul_state_e  state_q, state_d;
  logic        start_l_q, start_l_d;
  logic        len_q, len_d;
  logic        rsi_q, rsi_d;
  logic [15:0] a_q, a_d;        // multiplicand magnitude
  logic [15:0] b_q, b_d;        // multiplier magnitude; low product bits shift in at the top
  logic [16:0] acc_q, acc_d;    // partial sum, one extra bit for the carry
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  logic        s0, s1;
  logic [7:0]  neg0_8, neg1_8;
  logic [15:0] neg0_16, neg1_16;
  logic [15:0] mag0, mag1;
  logic        trig;
  logic [15:0] addend;
  logic [16:0] sum;
  logic [31:0] mag_res, neg32, res;
  logic [15:0] neg16;
  logic        last;

  // Operand sign bits, magnitudes, start edge and one shift-add step
  always_comb begin
    s0      = len ? op0[15] : op0[7];
    s1      = len ? op1[15] : op1[7];
    neg0_8  = -op0[7:0];
    neg1_8  = -op1[7:0];
    neg0_16 = -op0;
    neg1_16 = -op1;
    if (sign && s0) mag0 = len ? neg0_16 : {8'h00, neg0_8};
    else            mag0 = len ? op0     : {8'h00, op0[7:0]};
    if (sign && s1) mag1 = len ? neg1_16 : {8'h00, neg1_8};
    else            mag1 = len ? op1     : {8'h00, op1[7:0]};

    trig   = start && !start_l_q;
    addend = b_q[0] ? a_q : 16'h0000;
    sum    = {1'b0, acc_q[16:1]} + {1'b0, addend};

    // Product as it stands once the current step is folded in
    mag_res = len_q ? {sum, b_q[15:1]} : {16'h0000, sum[8:0], b_q[15:9]};
    neg32   = -mag_res;
    neg16   = -mag_res[15:0];
    if (!rsi_q)     res = mag_res;
    else if (len_q) res = neg32;
    else            res = {{16{neg16[15]}}, neg16};

    last = (cnt_q == (len_q ? MUL16_LAST : MUL8_LAST));
  end

  // Next-state: idle waits for a start edge, run performs one step per cen
  always_comb begin
    state_d   = state_q;
    start_l_d = start_l_q;
    len_d     = len_q;
    rsi_d     = rsi_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    z_d       = z_q;
    n_d       = n_q;
    if (cen) begin
      start_l_d = start;
      unique case (state_q)
        MUL_IDLE: begin
          if (trig) begin
            state_d = MUL_RUN;
            len_d   = len;
            rsi_d   = sign & (s0 ^ s1);
            a_d     = mag0;
            b_d     = mag1;
            acc_d   = '0;
            cnt_d   = '0;
            prod_d  = '0;
            z_d     = 1'b0;
            n_d     = 1'b0;
          end
        end
        MUL_RUN: begin
          acc_d = sum;
          b_d   = {sum[0], b_q[15:1]};
          cnt_d = cnt_q + 4'd1;
          if (last) begin
            state_d = MUL_IDLE;
            cnt_d   = '0;
            prod_d  = res;
            z_d     = (res == 32'h0);
            n_d     = len_q ? res[31] : res[15];
          end
        end
        default: state_d = MUL_IDLE;
      endcase
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MUL_IDLE;
      start_l_q <= 1'b0;
      len_q     <= 1'b0;
      rsi_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_l_q <= start_l_d;
      len_q     <= len_d;
      rsi_q     <= rsi_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      z_q       <= z_d;
      n_q       <= n_d;
    end
  end

  assign prod = prod_q;
  assign busy = (state_q == MUL_RUN);
  assign z    = z_q;
  assign n    = n_q;

endmodule

// File: tb/tb_jtkcpu_mul.sv
// tb/tb_jtkcpu_mul.sv - directed self-checking bench for jtkcpu_mul
module tb_jtkcpu_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [15:0] op0 = '0;
  logic [15:0] op1 = '0;
  logic        len = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] prod;
  logic        busy;
  logic        z;
  logic        n;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit div3     = 1'b0;
  int ph       = 0;

  jtkcpu_mul dut (
    .rst   (rst),
    .clk   (clk),
    .cen   (cen),
    .op0   (op0),
    .op1   (op1),
    .len   (len),
    .start (start),
    .sign  (sign),
    .prod  (prod),
    .busy  (busy),
    .z     (z),
    .n     (n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to the next falling edge and set cen for the coming rising edge
  task automatic step_clk();
    @(negedge clk);
    if (div3) begin
      ph  = (ph + 1) % 3;
      cen = (ph == 0);
    end else begin
      cen = 1'b1;
    end
  endtask

  // Count falling edges with busy high until busy drops again
  task automatic wait_done(output int cyc);
    int  guard;
    bit  seen;
    cyc   = 0;
    seen  = 1'b0;
    guard = 0;
    while (guard < 400 && !(seen && !busy)) begin
      step_clk();
      guard++;
      if (busy) begin
        seen = 1'b1;
        cyc++;
      end
    end
    if (guard >= 400) check("timeout", 32'(guard), 32'd0);
  endtask

  task automatic run_mul(input logic l, input logic s, input logic [15:0] a,
                         input logic [15:0] b, output int cyc);
    len   = l;
    sign  = s;
    op0   = a;
    op1   = b;
    start = 1'b1;
    wait_done(cyc);
    start = 1'b0;
    repeat (3) step_clk();
  endtask

  initial begin
    int  cyc;
    int  guard;
    bit  restarted;
    logic [31:0] held;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_prod", prod, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_n", 32'(n), 32'd0);
    rst = 1'b0;
    step_clk();

    // Unsigned 8x8
    run_mul(1'b0, 1'b0, 16'h00FF, 16'h00FF, cyc);
    check("mul8_cycles", 32'(cyc), 32'd8);
    check("mul8_prod", prod, 32'h0000FE01);
    check("mul8_z", 32'(z), 32'd0);
    check("mul8_n", 32'(n), 32'd1);
    repeat (5) step_clk();
    check("mul8_hold", prod, 32'h0000FE01);

    // Unsigned 16x16 maximum
    run_mul(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, cyc);
    check("mul16_cycles", 32'(cyc), 32'd16);
    check("mul16_prod", prod, 32'hFFFE0001);

    // Signed mixed-sign 16x16
    run_mul(1'b1, 1'b1, 16'hFFFE, 16'h0003, cyc);
    check("smul16_prod", prod, 32'hFFFFFFFA);
    check("smul16_n", 32'(n), 32'd1);

    // Signed most-negative operands
    run_mul(1'b0, 1'b1, 16'h0080, 16'h0080, cyc);
    check("s80x80", prod, 32'h00004000);
    run_mul(1'b1, 1'b1, 16'h8000, 16'h8000, cyc);
    check("s8000x8000", prod, 32'h40000000);

    // Signed zero operand against a negative one
    run_mul(1'b1, 1'b1, 16'h0000, 16'hFFFF, cyc);
    check("zero_prod", prod, 32'h0);
    check("zero_z", 32'(z), 32'd1);
    check("zero_n", 32'(n), 32'd0);

    // Signed 8x8 ignores the high byte and sign-extends the result
    run_mul(1'b0, 1'b1, 16'hABFE, 16'h5503, cyc);
    check("smul8_prod", prod, 32'hFFFFFFFA);
    check("smul8_n", 32'(n), 32'd1);

    // cen one clock in three, start held, inputs and start toggled mid-run
    @(negedge clk);
    div3  = 1'b1;
    ph    = 0;
    cen   = 1'b1;
    len   = 1'b1;
    sign  = 1'b0;
    op0   = 16'h1234;
    op1   = 16'h0010;
    start = 1'b1;
    cyc   = 0;
    guard = 0;
    while (guard < 400 && !(cyc > 0 && !busy)) begin
      step_clk();
      guard++;
      if (busy) begin
        cyc++;
        if (cyc == 10) begin
          op0 = 16'hFFFF;
          op1 = 16'hFFFF;
          len = 1'b0;
          sign = 1'b1;
        end
        if (cyc == 20) start = 1'b0;
        if (cyc == 23) start = 1'b1;
      end
    end
    if (guard >= 400) check("cen3_timeout", 32'(guard), 32'd0);
    check("cen3_cycles", 32'(cyc), 32'd48);
    check("cen3_prod", prod, 32'h00012340);
    held      = prod;
    restarted = 1'b0;
    repeat (30) begin
      step_clk();
      if (busy) restarted = 1'b1;
    end
    check("held_start_no_restart", 32'(restarted), 32'd0);
    check("held_start_prod", prod, held);
    start = 1'b0;
    repeat (6) step_clk();
    div3 = 1'b0;
    step_clk();

    // Reset mid-run, start still high re-triggers after release
    len   = 1'b1;
    sign  = 1'b0;
    op0   = 16'h0101;
    op1   = 16'h0101;
    start = 1'b1;
    cyc   = 0;
    guard = 0;
    while (guard < 50 && cyc < 5) begin
      step_clk();
      guard++;
      if (busy) cyc++;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_prod", prod, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(cyc);
    check("after_rst_cycles", 32'(cyc), 32'd16);
    check("after_rst_prod", prod, 32'h00010201);
    start = 1'b0;
    repeat (3) step_clk();

    // Fresh start edge after the abort
    run_mul(1'b1, 1'b0, 16'h1234, 16'h0010, cyc);
    check("post_abort_prod", prod, 32'h00012340);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
